// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fwd_hazard_unit_pkg                                            |
// | Brief   : Shared forward-select encodings and helpers for the hazard unit|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fwd_hazard_unit_pkg;

  localparam int unsigned c_sel_w = 3;

  localparam logic [c_sel_w-1:0] c_fwd_sel_rf  = 3'd0;
  localparam logic [c_sel_w-1:0] c_fwd_sel_exe = 3'd1;
  localparam logic [c_sel_w-1:0] c_fwd_sel_mem = 3'd2;
  localparam logic [c_sel_w-1:0] c_fwd_sel_wb  = 3'd3;

  localparam int unsigned c_gpr_zero = 0;

  // Stage i is reported as select code i+1; code 0 is reserved for the regfile.
  function automatic logic [c_sel_w-1:0] stage_to_sel(input int unsigned idx);
    return c_sel_w'(idx + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_port_sel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fwd_port_sel                                                   |
// | Brief   : Youngest-hit priority match of one read port over scoreboard   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fwd_port_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_RDY = 2
) (
  input  logic [STAGES-1:0]        sb_vld,
  input  logic [STAGES-1:0]        sb_wen,
  input  logic [STAGES-1:0]        sb_load,
  input  logic [STAGES*ADDR_W-1:0] sb_waddr,
  input  logic [STAGES*DATA_W-1:0] stage_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rf_data,
  output logic [c_sel_w-1:0]       sel,
  output logic [DATA_W-1:0]        data,
  output logic                     not_ready
);

  logic [STAGES-1:0] w_hit;
  logic              w_addr_nonzero;

  assign w_addr_nonzero = (rd_addr != ADDR_W'(c_gpr_zero));

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_hit
      assign w_hit[gi] = sb_vld[gi] & sb_wen[gi] & w_addr_nonzero &
                         (sb_waddr[gi*ADDR_W +: ADDR_W] == rd_addr);
    end
  endgenerate

  // Walk oldest to youngest so the youngest hit is the last (winning) write.
  always_comb begin
    sel       = c_fwd_sel_rf;
    data      = rf_data;
    not_ready = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        sel       = stage_to_sel(i);
        data      = stage_data[i*DATA_W +: DATA_W];
        not_ready = sb_load[i] & (i < LOAD_RDY);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fwd_hazard_unit                                                |
// | Brief   : Operand forwarding, load-use interlock and stall-cycle counter |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int STAGES   = 3,
  parameter int RD_PORTS = 2,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic                         id_wen,
  input  logic [ADDR_W-1:0]            id_waddr,
  input  logic                         id_is_load,
  input  logic                         flush,
  input  logic [STAGES*DATA_W-1:0]     stage_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS*DATA_W-1:0]   rf_data,
  output logic [RD_PORTS*DATA_W-1:0]   fwd_data,
  output logic [RD_PORTS*c_sel_w-1:0]  fwd_sel,
  output logic                         stall,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic [STAGES-1:0]        r_sb_vld;
  logic [STAGES-1:0]        r_sb_wen;
  logic [STAGES-1:0]        r_sb_load;
  logic [STAGES*ADDR_W-1:0] r_sb_waddr;
  logic [CNT_W-1:0]         r_stall_cnt;
  logic [RD_PORTS-1:0]      w_not_ready;
  logic                     w_issue;

  generate
    for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_port
      fwd_port_sel #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .STAGES   (STAGES),
        .LOAD_RDY (LOAD_RDY)
      ) u_port_sel (
        .sb_vld     (r_sb_vld),
        .sb_wen     (r_sb_wen),
        .sb_load    (r_sb_load),
        .sb_waddr   (r_sb_waddr),
        .stage_data (stage_data),
        .rd_addr    (rd_addr[gp*ADDR_W +: ADDR_W]),
        .rf_data    (rf_data[gp*DATA_W +: DATA_W]),
        .sel        (fwd_sel[gp*c_sel_w +: c_sel_w]),
        .data       (fwd_data[gp*DATA_W +: DATA_W]),
        .not_ready  (w_not_ready[gp])
      );
    end
  endgenerate

  // A flush kills the ID instruction, so it can never also be waiting on a load.
  assign stall   = id_valid & ~flush & (|w_not_ready);
  assign w_issue = id_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_vld   <= '0;
      r_sb_wen   <= '0;
      r_sb_load  <= '0;
      r_sb_waddr <= '0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        r_sb_vld[i]                   <= r_sb_vld[i-1];
        r_sb_wen[i]                   <= r_sb_wen[i-1];
        r_sb_load[i]                  <= r_sb_load[i-1];
        r_sb_waddr[i*ADDR_W +: ADDR_W] <= r_sb_waddr[(i-1)*ADDR_W +: ADDR_W];
      end
      r_sb_vld[0]             <= w_issue;
      r_sb_wen[0]             <= w_issue & id_wen;
      r_sb_load[0]            <= w_issue & id_is_load;
      r_sb_waddr[ADDR_W-1:0]  <= w_issue ? id_waddr : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
